// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks outstanding writers per architectural register
// and gates uop issue on RAW hazards, counter saturation and (optionally) WAW.
module reg_scoreboard #(
    parameter int unsigned NREGS     = 32,
    parameter int unsigned RIDX_W    = 5,
    parameter int unsigned CNT_W     = 2,
    parameter int unsigned NWB       = 2,
    parameter int unsigned BYPASS_WB = 1,
    parameter int unsigned WAW_STALL = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  iss_valid,
    output logic                  iss_ready,
    input  logic [NREGS-1:0]      iss_src_mask,
    input  logic [1:0]            iss_dst_vld,
    input  logic [2*RIDX_W-1:0]   iss_dst_idx,
    input  logic [NWB-1:0]        wb_valid,
    input  logic [NWB*RIDX_W-1:0] wb_idx,
    input  logic                  flush,
    output logic [NREGS-1:0]      busy,
    output logic [31:0]           stall_cnt,
    output logic                  err_underflow
);

    localparam int unsigned DecW = $clog2(NWB + 1);
    // Wide enough for count + 1 and for the largest release count.
    localparam int unsigned SumW = ((CNT_W > DecW) ? CNT_W : DecW) + 1;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [CNT_W-1:0] cnt_q [NREGS];
    logic [CNT_W-1:0] cnt_d [NREGS];
    logic [DecW-1:0]  dec   [NREGS];
    logic [NREGS-1:0] inc_req;
    logic [NREGS-1:0] rel_any;
    logic [NREGS-1:0] eff_busy;
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             hazard;
    logic             sat;
    logic             waw;
    logic             fire;
    logic             underflow;
    logic [SumW-1:0]  sum;
    logic [31:0]      stall_cnt_q;
    logic [31:0]      stall_cnt_d;
    logic             err_q;

    assign busy          = busy_q;
    assign stall_cnt     = stall_cnt_q;
    assign err_underflow = err_q;

    // Decode destination and release ports into per-register requests; indices
    // at or above NREGS never match a register and are silently dropped.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            inc_req[i] = 1'b0;
            dec[i]     = '0;
            for (int s = 0; s < 2; s++) begin
                if (iss_dst_vld[s] && iss_dst_idx[s*RIDX_W +: RIDX_W] == RIDX_W'(i)) begin
                    inc_req[i] = 1'b1;
                end
            end
            for (int p = 0; p < NWB; p++) begin
                if (wb_valid[p] && wb_idx[p*RIDX_W +: RIDX_W] == RIDX_W'(i)) begin
                    dec[i] = dec[i] + DecW'(1);
                end
            end
            rel_any[i]  = (dec[i] != '0);
            // A last writer retiring this cycle lets a dependent uop go now.
            eff_busy[i] = busy_q[i] &&
                          !((BYPASS_WB != 0) && (cnt_q[i] == CNT_W'(1)) && rel_any[i]);
        end
    end

    // Issue gating: RAW hazard, destination counter saturation, optional WAW.
    always_comb begin
        hazard = |(iss_src_mask & eff_busy);
        sat    = 1'b0;
        waw    = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            // Saturation ignores same-cycle releases so the increment never wraps.
            if (inc_req[i] && cnt_q[i] == CMAX) sat = 1'b1;
            if (inc_req[i] && eff_busy[i])      waw = 1'b1;
        end
        iss_ready = !flush && !hazard && !sat && !((WAW_STALL != 0) && waw);
        fire      = iss_valid && iss_ready;
    end

    // Counter next state: count + inc - dec, clamped at zero with underflow flag.
    always_comb begin
        underflow = 1'b0;
        sum       = '0;
        for (int i = 0; i < NREGS; i++) begin
            sum = SumW'(cnt_q[i]) + SumW'(fire && inc_req[i]);
            if (sum < SumW'(dec[i])) begin
                cnt_d[i]  = '0;
                underflow = 1'b1;
            end else begin
                cnt_d[i] = CNT_W'(sum - SumW'(dec[i]));
            end
            busy_d[i] = (cnt_d[i] != '0);
        end
        if (flush) begin
            for (int i = 0; i < NREGS; i++) cnt_d[i] = '0;
            busy_d    = '0;
            underflow = 1'b0;
        end
    end

    // Saturating count of cycles where a valid uop was held back.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (iss_valid && !iss_ready && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // State registers; busy is registered so no wb_* path reaches it combinationally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) cnt_q[i] <= '0;
            busy_q      <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) cnt_q[i] <= cnt_d[i];
            busy_q      <= busy_d;
            stall_cnt_q <= stall_cnt_d;
            if (underflow) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: default instance plus a WAW_STALL=1 instance.
module tb_reg_scoreboard;

    logic        clk;
    logic        reset_n;
    logic        iss_valid;
    logic [31:0] iss_src_mask;
    logic [1:0]  iss_dst_vld;
    logic [9:0]  iss_dst_idx;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_idx;
    logic        flush;

    logic        rdy, w_rdy;
    logic [31:0] busy, w_busy;
    logic [31:0] stall, w_stall;
    logic        err, w_err;

    int checks = 0;
    int errors = 0;

    reg_scoreboard dut (
        .clk(clk), .reset_n(reset_n), .iss_valid(iss_valid), .iss_ready(rdy),
        .iss_src_mask(iss_src_mask), .iss_dst_vld(iss_dst_vld), .iss_dst_idx(iss_dst_idx),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .flush(flush), .busy(busy),
        .stall_cnt(stall), .err_underflow(err)
    );

    reg_scoreboard #(.WAW_STALL(1)) dut_waw (
        .clk(clk), .reset_n(reset_n), .iss_valid(iss_valid), .iss_ready(w_rdy),
        .iss_src_mask(iss_src_mask), .iss_dst_vld(iss_dst_vld), .iss_dst_idx(iss_dst_idx),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .flush(flush), .busy(w_busy),
        .stall_cnt(w_stall), .err_underflow(w_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid    = 1'b0;
        iss_src_mask = '0;
        iss_dst_vld  = '0;
        iss_dst_idx  = '0;
        wb_valid     = '0;
        wb_idx       = '0;
        flush        = 1'b0;
    endtask

    task automatic issue(input logic [4:0] d);
        iss_valid   = 1'b1;
        iss_dst_vld = 2'b01;
        iss_dst_idx = {5'd0, d};
    endtask

    task automatic wb1(input logic [4:0] r);
        wb_valid = 2'b01;
        wb_idx   = {5'd0, r};
    endtask

    task automatic wb2(input logic [4:0] r);
        wb_valid = 2'b11;
        wb_idx   = {r, r};
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_stall", 64'(stall), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("rst_ready", 64'(rdy), 64'h1);
        flush = 1'b1;
        #1;
        chk("rst_ready_flush", 64'(rdy), 64'h0);
        flush = 1'b0;
        #1;
        reset_n = 1'b1;
        tick();

        // RAW hazard on r3 and same-cycle bypass release
        idle(); issue(5'd3);
        #1 chk("iss3_ready", 64'(rdy), 64'h1);
        tick();
        chk("busy3_set", 64'(busy), 64'h8);
        idle(); iss_valid = 1'b1; iss_src_mask = 32'h8;
        #1 chk("raw_stall", 64'(rdy), 64'h0);
        wb1(5'd3);
        #1 chk("raw_bypass", 64'(rdy), 64'h1);
        tick();
        chk("busy3_clr", 64'(busy), 64'h0);
        chk("stall_0", 64'(stall), 64'h0);

        // Saturate r7 at CMAX=3, then a fourth writer stalls
        for (int k = 0; k < 3; k++) begin
            idle(); issue(5'd7);
            #1 chk("iss7_ready", 64'(rdy), 64'h1);
            tick();
        end
        chk("busy7_set", 64'(busy), 64'h80);
        issue(5'd7);
        #1 chk("sat_stall", 64'(rdy), 64'h0);
        tick();
        chk("stall_1", 64'(stall), 64'h1);
        idle(); wb2(5'd7);
        tick();
        chk("busy7_cnt1", 64'(busy), 64'h80);
        idle(); wb1(5'd7);
        tick();
        chk("busy7_clr", 64'(busy), 64'h0);
        chk("err_after7", 64'(err), 64'h0);

        // Two ports releasing r5 from count 2
        idle(); issue(5'd5); tick();
        #1 chk("iss5_ready", 64'(rdy), 64'h1);
        tick();
        chk("busy5_set", 64'(busy), 64'h20);
        idle(); wb2(5'd5);
        tick();
        chk("busy5_clr", 64'(busy), 64'h0);
        chk("err_after5", 64'(err), 64'h0);

        // Both dst slots naming r2 count once
        idle(); iss_valid = 1'b1; iss_dst_vld = 2'b11; iss_dst_idx = {5'd2, 5'd2};
        tick();
        chk("busy2_set", 64'(busy), 64'h4);
        idle(); wb1(5'd2);
        tick();
        chk("busy2_clr", 64'(busy), 64'h0);
        chk("err_after2", 64'(err), 64'h0);

        // Flush with a simultaneous issue to r4
        idle(); issue(5'd10); tick();
        chk("busy10_set", 64'(busy), 64'h400);
        idle(); flush = 1'b1; issue(5'd4);
        #1 chk("flush_ready", 64'(rdy), 64'h0);
        tick();
        chk("flush_busy", 64'(busy), 64'h0);
        chk("stall_flush", 64'(stall), 64'h2);

        // Underflow on r9 is sticky through flush
        idle(); wb1(5'd9);
        tick();
        chk("uf9_err", 64'(err), 64'h1);
        chk("uf9_busy", 64'(busy), 64'h0);
        idle(); flush = 1'b1;
        tick();
        chk("uf_sticky", 64'(err), 64'h1);

        // Asynchronous reset mid-operation discards writers
        idle(); issue(5'd12); tick();
        chk("busy12_set", 64'(busy), 64'h1000);
        idle();
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'h0);
        chk("arst_err", 64'(err), 64'h0);
        chk("arst_stall", 64'(stall), 64'h0);
        #1 reset_n = 1'b1;
        wb1(5'd12);
        tick();
        chk("post_rst_uf", 64'(err), 64'h1);

        // WAW_STALL instance
        idle();
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
        issue(5'd6);
        tick();
        chk("w_busy6_set", 64'(w_busy), 64'h40);
        #1 chk("w_waw_stall", 64'(w_rdy), 64'h0);
        chk("d_no_waw", 64'(rdy), 64'h1);
        wb1(5'd6);
        #1 chk("w_waw_bypass", 64'(w_rdy), 64'h1);
        tick();
        chk("w_busy6_cnt1", 64'(w_busy), 64'h40);
        idle(); wb1(5'd6);
        tick();
        chk("w_busy6_clr", 64'(w_busy), 64'h0);
        chk("w_err", 64'(w_err), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time bound so the bench always terminates.
    initial begin
        #20000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter NREGS, default 32, meaning number of tracked architectural registers.
REQ-002 SHALL have parameter RIDX_W, default 5, meaning register index width, with 2^RIDX_W >= NREGS.
REQ-003 SHALL have parameter CNT_W, default 2, meaning per-register outstanding-writer counter width.
REQ-004 SHALL have parameter NWB, default 2, meaning number of writeback release ports.
REQ-005 SHALL have parameter BYPASS_WB, default 1; when 1, a same-cycle final release clears the hazard.
REQ-006 SHALL have parameter WAW_STALL, default 0; when 1, issue stalls while any destination count is nonzero.
REQ-007 SHALL have ports: clk  in  1  clock; reset_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have ports: iss_valid  in  1  issue request; iss_ready  out  1  issue accepted this cycle (combinational).
REQ-009 SHALL have ports: iss_src_mask  in  NREGS  registers read by the issuing uop.
REQ-010 SHALL have ports: iss_dst_vld  in  2; iss_dst_idx  in  2*RIDX_W  two destination slots (pair-write ops such as RDX:RAX).
REQ-011 SHALL have ports: wb_valid  in  NWB; wb_idx  in  NWB*RIDX_W  release one writer per valid port.
REQ-012 SHALL have ports: flush  in  1  discard all outstanding writers.
REQ-013 SHALL have ports: busy  out  NREGS  registered, bit i = (count[i] != 0).
REQ-014 SHALL have ports: stall_cnt  out  32  registered saturating count of cycles with iss_valid && !iss_ready; err_underflow  out  1  sticky.

Function
REQ-015 SHALL hold one CNT_W-bit counter per register; CMAX = 2^CNT_W - 1.
REQ-016 SHALL compute hazard = |(iss_src_mask & eff_busy), where eff_busy[i] = busy[i], except that with BYPASS_WB=1 it is 0 when count[i]==1 and at least one wb port releases i this cycle.
REQ-017 SHALL compute sat = any valid dst slot whose count == CMAX; same-cycle releases are not credited.
REQ-018 SHALL, with WAW_STALL=1, additionally block issue when any valid dst slot has count != 0 (bypass rule of REQ-016 applies).
REQ-019 SHALL drive iss_ready = !flush && !hazard && !sat (and !waw when WAW_STALL=1), independent of iss_valid.
REQ-020 SHALL define an issue as fired when iss_valid && iss_ready.
REQ-021 SHALL, on fire, increment each distinct valid destination once; two slots naming the same register increment it by 1, not 2.
REQ-022 SHALL decrement each register by the number of wb ports naming it in that cycle (up to NWB).
REQ-023 SHALL update every counter as next = count + inc - dec in one cycle; busy reflects the result one cycle later.
REQ-024 SHALL, when count + inc < dec, clamp next to 0 and set err_underflow, which stays set until reset.
REQ-025 SHALL, on flush, set all counters to 0 on the next edge, ignoring same-cycle issue and wb; err_underflow is unaffected.
REQ-026 SHALL ignore wb_idx and iss_dst_idx values >= NREGS (no count change, no error).
REQ-027 SHALL increment stall_cnt each cycle iss_valid && !iss_ready, saturating at 32'hFFFF_FFFF; flush does not clear it.
REQ-028 SHALL keep the datapath free of combinational paths from wb_* to busy; busy comes from flops only.

Reset
REQ-029 SHALL, while reset_n is low, asynchronously force all counters, busy, stall_cnt and err_underflow to 0.
REQ-030 SHALL, with reset_n low, drive iss_ready from the zeroed state: 1 unless flush is asserted.
REQ-031 SHALL, on reset asserted mid-operation, discard all outstanding writers; releases arriving after deassertion underflow and set err_underflow.

Verification
REQ-032 SHALL cover: issue dst0=3; next cycle src_mask bit3 -> iss_ready=0; wb 3 -> iss_ready=1 in the same cycle (BYPASS_WB=1), busy[3]=0 on the next edge.
REQ-033 SHALL cover: three issues to dst 7, no wb (CNT_W=2) -> count 3; a fourth issue with dst 7 -> iss_ready=0, stall_cnt increments by 1.
REQ-034 SHALL cover: count[5]=2, wb_valid=2'b11, both ports name 5 -> count 0, busy[5]=0, err_underflow=0.
REQ-035 SHALL cover: count[9]=0, wb 9 -> count stays 0, err_underflow=1, persists through flush.
REQ-036 SHALL cover: dst0=dst1=2 on one issue -> count[2]=1; flush with simultaneous issue to 4 -> all busy=0, count[4]=0.
REQ-037 SHALL cover: WAW_STALL=1, count[6]=1, issue dst 6 without wb -> iss_ready=0; with wb 6 the same cycle -> fire, count[6]=1.
